// File: rtl/matinv_scale_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : matinv_pkg
//  Description : Shared types, default sizes and helpers for the sequential
//                matrix-inverse scaling back end.
//  Revision    : 1.0 - initial release
// ============================================================================
package matinv_pkg;

    localparam int unsigned DEF_DATA_WIDTH  = 16;
    localparam int unsigned DEF_BIN_POS     = 8;
    localparam int unsigned DEF_MATRIX_SIZE = 2;

    // Quotient length of the divider in the default configuration.
    localparam int unsigned K = DEF_DATA_WIDTH + DEF_BIN_POS;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CHECK = 3'd1,
        ST_DIV   = 3'd2,
        ST_WRITE = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    // Magnitude of a sign-extended two's-complement value. The most negative
    // narrow value maps to 2^(w-1), which still fits the unsigned width.
    function automatic logic [63:0] mag64(input logic [63:0] v);
        return v[63] ? (~v + 64'd1) : v;
    endfunction

    // Largest positive magnitude representable in w bits.
    function automatic logic [63:0] sat_pos(input int unsigned w);
        return (64'd1 << (w - 1)) - 64'd1;
    endfunction

    // Largest negative magnitude; also the bit pattern of the most negative value.
    function automatic logic [63:0] sat_neg(input int unsigned w);
        return 64'd1 << (w - 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/matinv_scale_seq_if.sv
`default_nettype none
// ============================================================================
//  Module      : matinv_scale_seq_if
//  Description : Job input / result output handshake bundle for
//                matinv_scale_seq.
//  Revision    : 1.0 - initial release
// ============================================================================
interface matinv_scale_seq_if #(
    parameter int unsigned DATA_WIDTH  = matinv_pkg::DEF_DATA_WIDTH,
    parameter int unsigned MATRIX_SIZE = matinv_pkg::DEF_MATRIX_SIZE
);
    localparam int unsigned BUS_W = MATRIX_SIZE * MATRIX_SIZE * DATA_WIDTH;

    logic                  in_valid;
    logic                  in_ready;
    logic [BUS_W-1:0]      adj;
    logic [DATA_WIDTH-1:0] det;
    logic                  out_valid;
    logic                  out_ready;
    logic [BUS_W-1:0]      inv;
    logic                  singular;
    logic                  overflow;

    // Job source and result consumer side.
    modport master (
        output in_valid, adj, det, out_ready,
        input  in_ready, out_valid, inv, singular, overflow
    );

    // The scaling engine side.
    modport slave (
        input  in_valid, adj, det, out_ready,
        output in_ready, out_valid, inv, singular, overflow
    );
endinterface
`default_nettype wire

// File: rtl/matinv_scale_seq_fxp_div_seq.sv
`default_nettype none
// ============================================================================
//  Module      : fxp_div_seq
//  Description : Unsigned restoring divider, one quotient bit per cycle, MSB
//                first. The quotient is valid K cycles after start.
//  Revision    : 1.0 - initial release
// ============================================================================
module fxp_div_seq #(
    parameter int unsigned DATA_WIDTH = matinv_pkg::DEF_DATA_WIDTH,
    parameter int unsigned K          = matinv_pkg::K
) (
    input  wire logic                  clk,
    input  wire logic                  rst_n,
    input  wire logic                  start,
    input  wire logic [K-1:0]          dividend,
    input  wire logic [DATA_WIDTH-1:0] divisor,
    output logic                       busy,
    output logic [K-1:0]               quotient
);
    localparam int unsigned CW = $clog2(K + 1);

    logic [K-1:0]          r_dvd;
    logic [K-1:0]          r_quo;
    logic [DATA_WIDTH-1:0] r_rem;
    logic [DATA_WIDTH-1:0] r_dsr;
    logic [CW-1:0]         r_cnt;
    logic [DATA_WIDTH:0]   w_trial;
    logic                  w_ge;

    // Trial subtraction: shift the next dividend bit into the partial remainder.
    always_comb begin
        w_trial = {r_rem, r_dvd[K-1]};
        w_ge    = (w_trial >= {1'b0, r_dsr});
    end

    // Load on start, then iterate until the bit counter runs out.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_dvd <= '0;
            r_quo <= '0;
            r_rem <= '0;
            r_dsr <= '0;
            r_cnt <= '0;
        end else if (start) begin
            r_dvd <= dividend;
            r_dsr <= divisor;
            r_rem <= '0;
            r_quo <= '0;
            r_cnt <= CW'(K);
        end else if (r_cnt != '0) begin
            r_dvd <= {r_dvd[K-2:0], 1'b0};
            r_quo <= {r_quo[K-2:0], w_ge};
            // The remainder is always below the divisor, so W bits hold it.
            r_rem <= w_ge ? DATA_WIDTH'(w_trial - {1'b0, r_dsr}) : w_trial[DATA_WIDTH-1:0];
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign busy     = (r_cnt != '0);
    assign quotient = r_quo;

endmodule
`default_nettype wire

// File: rtl/matinv_scale_seq.sv
`default_nettype none
// ============================================================================
//  Module      : matinv_scale_seq
//  Description : Divides every adjugate element by the determinant with one
//                shared restoring divider, applying sign and saturation, to
//                produce the matrix inverse in signed fixed point.
//  Revision    : 1.0 - initial release
// ============================================================================
module matinv_scale_seq
    import matinv_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int unsigned BIN_POS     = DEF_BIN_POS,
    parameter int unsigned MATRIX_SIZE = DEF_MATRIX_SIZE
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    matinv_scale_seq_if.slave bus
);
    localparam int unsigned KW     = DATA_WIDTH + BIN_POS;
    localparam int unsigned NUM_EL = MATRIX_SIZE * MATRIX_SIZE;
    localparam int unsigned BUS_W  = NUM_EL * DATA_WIDTH;
    localparam int unsigned IDX_W  = $clog2(NUM_EL);
    localparam int unsigned BIT_W  = $clog2(KW);

    localparam logic [KW-1:0]         C_POS_LIM  = KW'(sat_pos(DATA_WIDTH));
    localparam logic [KW-1:0]         C_NEG_LIM  = KW'(sat_neg(DATA_WIDTH));
    localparam logic [DATA_WIDTH-1:0] C_SAT_POS  = DATA_WIDTH'(sat_pos(DATA_WIDTH));
    localparam logic [DATA_WIDTH-1:0] C_SAT_NEG  = DATA_WIDTH'(sat_neg(DATA_WIDTH));
    localparam logic [IDX_W-1:0]      C_LAST_IDX = IDX_W'(NUM_EL - 1);
    localparam logic [BIT_W-1:0]      C_LAST_BIT = BIT_W'(KW - 1);

    state_t                r_state;
    state_t                w_next;
    logic [BUS_W-1:0]      r_adj;
    logic [DATA_WIDTH-1:0] r_det;
    logic [IDX_W-1:0]      r_idx;
    logic [BIT_W-1:0]      r_bit;
    logic [BUS_W-1:0]      r_inv;
    logic                  r_sing;
    logic                  r_ovf;

    logic [DATA_WIDTH-1:0] w_adj_el [NUM_EL];
    logic [IDX_W-1:0]      w_start_idx;
    logic [DATA_WIDTH-1:0] w_start_el;
    logic [DATA_WIDTH-1:0] w_start_mag;
    logic [DATA_WIDTH-1:0] w_det_mag;
    logic [DATA_WIDTH-1:0] w_cur_el;
    logic                  w_start;
    logic                  w_busy;
    logic [KW-1:0]         w_quo;
    logic                  w_neg;
    logic [DATA_WIDTH-1:0] w_res;
    logic                  w_res_ovf;

    // Row-major view of the captured adjugate.
    for (genvar gi = 0; gi < NUM_EL; gi++) begin : g_unpack
        assign w_adj_el[gi] = r_adj[gi*DATA_WIDTH +: DATA_WIDTH];
    end

    // Operand selection: CHECK launches element 0, WRITE launches the next one.
    always_comb begin
        w_start_idx = (r_state == ST_CHECK) ? '0 : (r_idx + 1'b1);
        w_start_el  = w_adj_el[w_start_idx];
        w_start_mag = DATA_WIDTH'(mag64({{(64-DATA_WIDTH){w_start_el[DATA_WIDTH-1]}}, w_start_el}));
        w_det_mag   = DATA_WIDTH'(mag64({{(64-DATA_WIDTH){r_det[DATA_WIDTH-1]}}, r_det}));
        w_cur_el    = w_adj_el[r_idx];
    end

    fxp_div_seq #(
        .DATA_WIDTH (DATA_WIDTH),
        .K          (KW)
    ) u_div (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (w_start),
        .dividend ({w_start_mag, {BIN_POS{1'b0}}}),
        .divisor  (w_det_mag),
        .busy     (w_busy),
        .quotient (w_quo)
    );

    // Sign restoration and saturation of the finished quotient.
    always_comb begin
        w_res     = '0;
        w_res_ovf = 1'b0;
        w_neg     = (w_cur_el[DATA_WIDTH-1] ^ r_det[DATA_WIDTH-1]) && (w_quo != '0);
        if (w_neg) begin
            if (w_quo > C_NEG_LIM) begin
                w_res     = C_SAT_NEG;
                w_res_ovf = 1'b1;
            end else begin
                w_res = -w_quo[DATA_WIDTH-1:0];
            end
        end else begin
            if (w_quo > C_POS_LIM) begin
                w_res     = C_SAT_POS;
                w_res_ovf = 1'b1;
            end else begin
                w_res = w_quo[DATA_WIDTH-1:0];
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_next;
    end

    // Next-state logic.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (bus.in_valid) w_next = ST_CHECK;
            ST_CHECK: w_next = (r_det == '0) ? ST_DONE : ST_DIV;
            ST_DIV:   if (r_bit == C_LAST_BIT) w_next = ST_WRITE;
            ST_WRITE: w_next = (r_idx == C_LAST_IDX) ? ST_DONE : ST_DIV;
            ST_DONE:  if (bus.out_ready) w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    // Handshake outputs and divider launch; never restart a divide in flight.
    always_comb begin
        bus.in_ready  = (r_state == ST_IDLE);
        bus.out_valid = (r_state == ST_DONE);
        w_start       = (((r_state == ST_CHECK) && (r_det != '0)) ||
                         ((r_state == ST_WRITE) && (r_idx != C_LAST_IDX))) && !w_busy;
    end

    // Job capture, element sequencing and result storage.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_adj  <= '0;
            r_det  <= '0;
            r_idx  <= '0;
            r_bit  <= '0;
            r_inv  <= '0;
            r_sing <= 1'b0;
            r_ovf  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        r_adj  <= bus.adj;
                        r_det  <= bus.det;
                        r_inv  <= '0;
                        r_sing <= 1'b0;
                        r_ovf  <= 1'b0;
                    end
                end
                ST_CHECK: begin
                    r_idx <= '0;
                    r_bit <= '0;
                    if (r_det == '0) r_sing <= 1'b1;
                end
                ST_DIV: begin
                    r_bit <= r_bit + 1'b1;
                end
                ST_WRITE: begin
                    for (int i = 0; i < NUM_EL; i++) begin
                        if (r_idx == IDX_W'(i)) r_inv[i*DATA_WIDTH +: DATA_WIDTH] <= w_res;
                    end
                    r_ovf <= r_ovf | w_res_ovf;
                    r_idx <= r_idx + 1'b1;
                    r_bit <= '0;
                end
                default: ;
            endcase
        end
    end

    assign bus.inv      = r_inv;
    assign bus.singular = r_sing;
    assign bus.overflow = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_matinv_scale_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_matinv_scale_seq
//  Description : Directed self-checking bench for matinv_scale_seq at
//                DATA_WIDTH=16, BIN_POS=8, MATRIX_SIZE=2.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_matinv_scale_seq;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;

    matinv_scale_seq_if #(.DATA_WIDTH(16), .MATRIX_SIZE(2)) bus ();

    matinv_scale_seq #(
        .DATA_WIDTH  (16),
        .BIN_POS     (8),
        .MATRIX_SIZE (2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [63:0] adj;   // {el3, el2, el1, el0}
        logic [15:0] det;
        logic [63:0] inv;
        logic        sing;
        logic        ovf;
        int          lat;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    // Wait (bounded) for out_valid, sampling 1ns after each edge; returns edge count.
    task automatic wait_out(output int lat);
        lat = 0;
        while (lat < 300) begin
            @(posedge clk); #1;
            lat++;
            if (bus.out_valid) break;
        end
    endtask

    // Full job with out_ready held high.
    task automatic run_vec(input int k);
        int lat;
        @(negedge clk);
        bus.adj       = vecs[k].adj;
        bus.det       = vecs[k].det;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        check({vecs[k].name, "_ready"}, 80'(bus.in_ready), 80'(1));
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.adj      = {$urandom, $urandom};
        bus.det      = 16'($urandom);
        check({vecs[k].name, "_busy"}, 80'(bus.in_ready), 80'(0));
        wait_out(lat);
        check({vecs[k].name, "_lat"}, 80'(lat), 80'(vecs[k].lat));
        check({vecs[k].name, "_inv"}, 80'(bus.inv), 80'(vecs[k].inv));
        check({vecs[k].name, "_flags"}, 80'({bus.singular, bus.overflow}),
              80'({vecs[k].sing, vecs[k].ovf}));
        @(posedge clk); #1;
        check({vecs[k].name, "_handoff"}, 80'({bus.out_valid, bus.in_ready}), 80'(2'b01));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        n_cmp = 0;
        n_err = 0;

        vecs[0] = '{"scale",   64'h0100_0000_0000_0100, 16'h0200, 64'h0080_0000_0000_0080, 1'b0, 1'b0, 101};
        vecs[1] = '{"sign_p",  64'h0080_FE00_0200_FF00, 16'h0300, 64'h002A_FF56_00AA_FFAB, 1'b0, 1'b0, 101};
        vecs[2] = '{"sign_n",  64'h0080_FE00_0200_FF00, 16'hFD00, 64'hFFD6_00AA_FF56_0055, 1'b0, 1'b0, 101};
        vecs[3] = '{"sat",     64'h0000_0001_8000_7FFF, 16'h0001, 64'h0000_0100_8000_7FFF, 1'b0, 1'b1, 101};
        vecs[4] = '{"det_m1",  64'h0080_0000_FFFF_0001, 16'hFFFF, 64'h8000_0000_0100_FF00, 1'b0, 1'b0, 101};
        vecs[5] = '{"det_min", 64'h0001_0100_7FFF_8000, 16'h8000, 64'h0000_FFFE_FF01_0100, 1'b0, 1'b0, 101};
        vecs[6] = '{"edge",    64'hFE80_0180_8000_7FFF, 16'h0100, 64'hFE80_0180_8000_7FFF, 1'b0, 1'b0, 101};
        vecs[7] = '{"sat_pos", 64'h0000_0000_0000_7FFF, 16'h00FF, 64'h0000_0000_0000_7FFF, 1'b0, 1'b1, 101};
        vecs[8] = '{"singular",64'h1234_5678_9ABC_DEF0, 16'h0000, 64'h0000_0000_0000_0000, 1'b1, 1'b0, 1};

        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        bus.adj       = '0;
        bus.det       = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_state", 80'({bus.in_ready, bus.out_valid, bus.singular, bus.overflow, bus.inv}),
              80'({1'b1, 1'b0, 1'b0, 1'b0, 64'h0}));
        @(negedge clk);
        rst_n = 1'b1;

        for (int k = 0; k < 9; k++) run_vec(k);

        // Backpressure: hold the result, with the next job already waiting.
        @(negedge clk);
        bus.adj       = vecs[0].adj;
        bus.det       = vecs[0].det;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b0;
        @(posedge clk); #1;
        bus.adj = vecs[1].adj;
        bus.det = vecs[1].det;
        wait_out(lat);
        check("bp_lat", 80'(lat), 80'(101));
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            check("bp_stall", 80'({bus.out_valid, bus.in_ready, bus.singular, bus.overflow, bus.inv}),
                  80'({1'b1, 1'b0, 1'b0, 1'b0, vecs[0].inv}));
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_idle", 80'({bus.out_valid, bus.in_ready}), 80'(2'b01));
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        check("bp_accept2", 80'(bus.in_ready), 80'(0));
        wait_out(lat);
        check("bp_lat2", 80'(lat), 80'(101));
        check("bp_inv2", 80'(bus.inv), 80'(vecs[1].inv));
        @(posedge clk); #1;

        // Singular job under backpressure: in_ready stays low until handoff.
        @(negedge clk);
        bus.adj       = vecs[8].adj;
        bus.det       = 16'h0000;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b0;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        check("sing_hold", 80'({bus.out_valid, bus.in_ready, bus.singular, bus.inv}),
              80'({1'b1, 1'b0, 1'b1, 64'h0}));
        repeat (3) @(posedge clk);
        #1;
        check("sing_hold2", 80'({bus.out_valid, bus.in_ready}), 80'(2'b10));
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        check("sing_release", 80'({bus.out_valid, bus.in_ready}), 80'(2'b01));

        // Reset in the middle of a job, after the first element is written.
        @(negedge clk);
        bus.adj      = vecs[1].adj;
        bus.det      = vecs[1].det;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (39) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("rst_mid", 80'({bus.in_ready, bus.out_valid, bus.singular, bus.overflow, bus.inv}),
              80'({1'b1, 1'b0, 1'b0, 1'b0, 64'h0}));
        @(negedge clk);
        rst_n = 1'b1;
        begin
            bit stale;
            stale = 1'b0;
            for (int c = 0; c < 150; c++) begin
                @(posedge clk); #1;
                if (bus.out_valid) stale = 1'b1;
            end
            check("rst_no_stale", 80'(stale), 80'(0));
        end
        run_vec(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
